// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port synchronous memory between the fetch requester (IF)
//   and the load/store requester (ME). ME has priority by default; an IF
//   requester denied STARVE_LIMIT cycles in a row is force-granted once.
//   A MEM_LAT-deep tag pipe remembers who owns each in-flight read so the
//   returning mem_rdata is routed to the right requester.
// Ports
//   clk, reset           clock, async active-low reset
//   if_req/if_addr       IF read request (held until if_gnt)
//   if_gnt/if_stall      IF issued this cycle / IF denied this cycle
//   if_rvalid/if_rdata   IF read response
//   me_req/we/addr/wdata/wstrb  ME request (held until me_gnt)
//   me_gnt               ME issued this cycle
//   me_rvalid/me_rdata   ME read response
//   mem_en/we/addr/wdata/wstrb  memory command port
//   mem_rdata            memory read data, MEM_LAT cycles after issue
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              me_req,
  input  logic              me_we,
  input  logic [ADDR_W-1:0] me_addr,
  input  logic [31:0]       me_wdata,
  input  logic [3:0]        me_wstrb,
  output logic              me_gnt,
  output logic              me_rvalid,
  output logic [31:0]       me_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [31:0]       mem_rdata,
  output logic              if_stall
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic {ME_PRI, IF_FORCE} arb_state_t;

  arb_state_t   state, state_nxt;
  logic [3:0]   starve_cnt, starve_nxt;
  logic [MEM_LAT-1:0] tag_vld, tag_own;   // tag_own: 1 = ME, 0 = IF
  logic [31:0]  if_rdata_q, me_rdata_q;
  logic         rsp_vld, rsp_own;

  // Grants and next state. Grants are gated by reset so every output drops
  // the moment reset is asserted, not at the next edge.
  always_comb begin
    if_gnt     = 1'b0;
    me_gnt     = 1'b0;
    starve_nxt = '0;
    state_nxt  = state;
    if (reset) begin
      if (state == IF_FORCE) begin
        if_gnt = if_req;
        me_gnt = me_req & ~if_req;
      end else begin
        me_gnt = me_req;
        if_gnt = if_req & ~me_req;
      end
    end
    if (if_req && !if_gnt)
      starve_nxt = (starve_cnt == LIMIT) ? starve_cnt : 4'(starve_cnt + 4'd1);
    case (state)
      // Switch on the count being loaded so IF wins the very next cycle
      // after its STARVE_LIMIT-th denial.
      ME_PRI:   if (starve_nxt == LIMIT) state_nxt = IF_FORCE;
      IF_FORCE: if (if_gnt || !if_req) state_nxt = ME_PRI;
      default:  state_nxt = ME_PRI;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ME_PRI;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  assign if_stall  = if_req & ~if_gnt & reset;
  assign mem_en    = if_gnt | me_gnt;
  assign mem_we    = me_gnt & me_we;
  assign mem_addr  = me_gnt ? me_addr : (if_gnt ? if_addr : '0);
  assign mem_wdata = me_gnt ? me_wdata : '0;
  assign mem_wstrb = me_gnt ? me_wstrb : '0;

  // Tag pipe: stage MEM_LAT-1 lines up with mem_rdata for the read it tags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_vld <= '0;
      tag_own <= '0;
    end else begin
      tag_vld[0] <= if_gnt | (me_gnt & ~me_we);
      tag_own[0] <= me_gnt;
      for (int i = MEM_LAT-1; i > 0; i--) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_own[i] <= tag_own[i-1];
      end
    end
  end

  assign rsp_vld   = tag_vld[MEM_LAT-1];
  assign rsp_own   = tag_own[MEM_LAT-1];
  assign if_rvalid = rsp_vld & ~rsp_own;
  assign me_rvalid = rsp_vld & rsp_own;

  // rdata shows live memory data with its rvalid and the captured copy after,
  // so the response is usable in the rvalid cycle and held afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_rdata_q <= '0;
      me_rdata_q <= '0;
    end else begin
      if (if_rvalid) if_rdata_q <= mem_rdata;
      if (me_rvalid) me_rdata_q <= mem_rdata;
    end
  end

  assign if_rdata = if_rvalid ? mem_rdata : if_rdata_q;
  assign me_rdata = me_rvalid ? mem_rdata : me_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed phases plus random traffic. A checker
// predicts grants from the starvation rule and pushes expected read responses
// (owner, data from a reference memory, due cycle) into a scoreboard; a
// separate monitor pops and compares whenever an rvalid appears.
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int LAT = 3;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          if_req = 1'b0, me_req = 1'b0, me_we = 1'b0;
  logic [AW-1:0] if_addr = '0, me_addr = '0;
  logic [31:0]   me_wdata = '0;
  logic [3:0]    me_wstrb = '0;
  logic          if_gnt, if_rvalid, me_gnt, me_rvalid, mem_en, mem_we, if_stall;
  logic [31:0]   if_rdata, me_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_wstrb;

  mem_port_arbiter #(.ADDR_W(AW), .MEM_LAT(LAT), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .me_req(me_req), .me_we(me_we), .me_addr(me_addr), .me_wdata(me_wdata),
    .me_wstrb(me_wstrb), .me_gnt(me_gnt), .me_rvalid(me_rvalid), .me_rdata(me_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .if_stall(if_stall)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory macro: synchronous, read data appears LAT cycles after issue.
  logic [31:0] mem_arr [0:255];
  logic [31:0] ref_mem [0:255];
  logic [31:0] rd_pipe [0:LAT-1];
  assign mem_rdata = rd_pipe[LAT-1];

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = $urandom;
      ref_mem[i] = mem_arr[i];
    end
    mem_arr[8'h80] = '0;  // word at 0x200
    ref_mem[8'h80] = '0;
  end

  always @(posedge clk) begin
    if (mem_en && mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) mem_arr[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
    rd_pipe[0] <= (mem_en && !mem_we) ? mem_arr[mem_addr[9:2]] : $urandom;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  // Scoreboard
  typedef struct { logic own; logic [31:0] data; int due; } rsp_t;
  rsp_t sb[$];
  int   denied = 0;

  // Checker: predicted grants, mem command and expected responses.
  always @(negedge clk) begin
    logic exp_if, exp_me;
    logic [AW-1:0] exp_addr;
    if (!reset) begin
      chk("rst_ctrl", {if_gnt, me_gnt, if_rvalid, me_rvalid, mem_en, mem_we, if_stall}, 0);
      chk("rst_rdata", {if_rdata, me_rdata}, 0);
      chk("rst_mem_bus", {mem_addr, mem_wstrb}, 0);
      denied = 0;
      sb.delete();
    end else begin
      exp_if   = if_req && (!me_req || denied >= LIM);
      exp_me   = me_req && !exp_if;
      exp_addr = exp_me ? me_addr : (exp_if ? if_addr : '0);
      chk("if_gnt", if_gnt, exp_if);
      chk("me_gnt", me_gnt, exp_me);
      chk("if_stall", if_stall, if_req && !exp_if);
      chk("mem_en", mem_en, exp_if || exp_me);
      chk("mem_we", mem_we, exp_me && me_we);
      chk("mem_addr", mem_addr, exp_addr);
      if (exp_me) chk("mem_wdata_strb", {mem_wdata, mem_wstrb}, {me_wdata, me_wstrb});
      denied = (if_req && !exp_if) ? denied + 1 : 0;
      if (exp_if) sb.push_back('{1'b0, ref_mem[if_addr[9:2]], cyc + LAT});
      if (exp_me && !me_we) sb.push_back('{1'b1, ref_mem[me_addr[9:2]], cyc + LAT});
      if (exp_me && me_we)
        for (int b = 0; b < 4; b++)
          if (me_wstrb[b]) ref_mem[me_addr[9:2]][8*b +: 8] = me_wdata[8*b +: 8];
    end
  end

  // Monitor: pops one expected response per rvalid.
  logic [31:0] last_if = '0, last_me = '0;
  always @(negedge clk) begin
    rsp_t e;
    if (!reset) begin
      last_if = '0;
      last_me = '0;
    end else begin
      if (if_rvalid && me_rvalid) chk("dual_rvalid", 1, 0);
      if (if_rvalid || me_rvalid) begin
        if (sb.size() == 0) chk("unexpected_rvalid", {if_rvalid, me_rvalid}, 0);
        else begin
          e = sb.pop_front();
          chk("rsp_owner", me_rvalid, e.own);
          chk("rsp_data", me_rvalid ? me_rdata : if_rdata, e.data);
          chk("rsp_latency", cyc, e.due);
        end
        if (if_rvalid) last_if = if_rdata;
        if (me_rvalid) last_me = me_rdata;
      end else begin
        if (sb.size() > 0 && sb[0].due <= cyc) begin
          chk("missing_rvalid", 0, 1);
          void'(sb.pop_front());
        end
        chk("rdata_hold", {if_rdata, me_rdata}, {last_if, last_me});
      end
    end
  end

  // Stimulus: one cycle; requests granted this cycle are dropped afterwards.
  logic g_if, g_me;
  task automatic cycle();
    @(negedge clk);
    g_if = if_gnt;
    g_me = me_gnt;
    @(posedge clk);
    #1;
    if (g_if) if_req = 1'b0;
    if (g_me) me_req = 1'b0;
  endtask

  task automatic me_read(input logic [AW-1:0] a);
    me_req = 1'b1; me_we = 1'b0; me_addr = a; me_wdata = '0; me_wstrb = '0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    drain(1);

    // IF streaming alone
    for (int i = 0; i < 3; i++) begin
      if_req = 1'b1; if_addr = 32'(4 * i);
      cycle();
      chk("if_stream_gnt", g_if, 1);
    end
    drain(LAT + 1);

    // Both request: ME first, IF the next cycle
    if_req = 1'b1; if_addr = 32'h10;
    me_read(32'h100);
    cycle();
    chk("both_me_first", {g_me, g_if}, 2'b10);
    cycle();
    chk("both_if_next", g_if, 1);
    drain(LAT + 1);

    // Starvation: ME continuous, IF held
    if_req = 1'b1; if_addr = 32'h20;
    n = 0;
    while (if_req && n < 20) begin
      if (!me_req) me_read({22'd0, 8'($urandom), 2'b00});
      cycle();
      n++;
    end
    chk("starve_grant_cycle", n, LIM + 1);
    if (!me_req) me_read(32'h24);
    cycle();
    chk("me_resume", g_me, 1);
    drain(LAT + 1);

    // Partial write then readback
    me_req = 1'b1; me_we = 1'b1; me_addr = 32'h200; me_wdata = 32'hDEADBEEF; me_wstrb = 4'b0011;
    cycle();
    me_read(32'h200);
    cycle();
    drain(LAT);
    chk("partial_write_rdata", me_rdata, 32'h0000BEEF);
    drain(1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if (!if_req && $urandom_range(0, 1) == 1) begin
        if_req = 1'b1; if_addr = {22'd0, 8'($urandom), 2'b00};
      end
      if (!me_req && $urandom_range(0, 2) != 0) begin
        me_req = 1'b1; me_we = ($urandom_range(0, 3) == 0);
        me_addr = {22'd0, 8'($urandom), 2'b00};
        me_wdata = $urandom; me_wstrb = 4'($urandom);
      end
      cycle();
    end
    if_req = 1'b0; me_req = 1'b0;
    drain(LAT + 2);

    // Reset with reads in flight and IF partly starved
    if_req = 1'b1; if_addr = 32'h30;
    for (int i = 0; i < 3; i++) begin
      if (!me_req) me_read({22'd0, 8'($urandom), 2'b00});
      cycle();
    end
    if (!me_req) me_read(32'h44);
    #2 reset = 1'b0;
    #1;
    chk("rst_immediate", {if_rvalid, me_rvalid, mem_en, if_gnt, me_gnt}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    // ME must again win LIM cycles: state and starve count were cleared
    for (int i = 0; i < LIM + 2; i++) begin
      if (!me_req) me_read({22'd0, 8'($urandom), 2'b00});
      if (!if_req) begin if_req = 1'b1; if_addr = 32'h34; end
      cycle();
    end
    if_req = 1'b0; me_req = 1'b0;
    drain(LAT + 3);
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
